commit_multi: RTL

- Parametrised N-wide successor to the single-slot commit stage.
- Retires up to CW in-order reorder-buffer head entries per cycle.
- Owns the architectural rename map register internally, instead of the map being held in the phy-register file, and releases physical-register writeback/rename-buffer bits.
- Raises a single abort per event (mispredict, ecall, ebreak, mret, interrupt) with a one-cycle flush state, and drives the trap CSR update.

---
 rtl/commit_multi_if.sv | 25 ++
 rtl/commit_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/commit_multi_if.sv
// Reorder-buffer head bundle between the ROB and the multi-slot commit stage.
// The ROB side is the master; the commit stage consumes entries and reports the pop count.
interface commit_multi_if #(
  parameter int CW  = 2,
  parameter int IDW = 77
);
  logic [CW*IDW-1:0] commit_fifo;
  logic [CW-1:0]     commit_vld;
  logic [CW-1:0]     isMisPredict;
  logic [2:0]        reOrder_fifo_pop;

  modport master (
    output commit_fifo,
    output commit_vld,
    output isMisPredict,
    input  reOrder_fifo_pop
  );

  modport slave (
    input  commit_fifo,
    input  commit_vld,
    input  isMisPredict,
    output reOrder_fifo_pop
  );
endinterface

// File: rtl/commit_multi.sv
// CW-wide in-order commit stage: retires ROB head entries, owns the committed rename map,
// raises one abort per trap/mispredict event. Optional macro COMMIT_INSTRET_EN adds instret_cnt.
module commit_multi #(
  parameter int CW = 2,
  parameter int RB = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  commit_multi_if.slave           rob,
  input  logic [32*(2**RB)-1:0]   wbLog_qout,
  output logic [32*(2**RB)-1:0]   wbLog_commit_rst,
  output logic [32*(2**RB)-1:0]   rnBufU_commit_rst,
  output logic [32*RB-1:0]        archi_X_qout,
  output logic                    commit_abort,
  output logic [63:0]             commit_pc,
  output logic                    suILP_ready,
  output logic [63:0]             privileged_pc,
  output logic                    isTrap,
  output logic                    isXRet,
  output logic [63:0]             mstatus_except_in,
  output logic [63:0]             mtval_except_in,
  output logic [63:0]             mcause_except_in,
  output logic [63:0]             mepc_except_in,
  input  logic [63:0]             mstatus_csr_out,
  input  logic [63:0]             mip_csr_out,
  input  logic [63:0]             mie_csr_out,
  input  logic [63:0]             mepc_csr_out,
  input  logic [63:0]             mtvec_csr_out
`ifdef COMMIT_INSTRET_EN
  ,
  output logic [63:0]             instret_cnt
`endif
);

  // Entry layout, MSB first: pc(64), rd0 = {reg(5), idx(RB)}, then six flag bits.
  localparam int IDW = 64 + 5 + RB + 6;
  localparam int RPW = 32 * (2**RB);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t state_q, state_d;

  logic [RB-1:0] archi_q [32];
  logic [RB-1:0] map_d   [32];

  logic [63:0]   pc_s    [CW];
  logic [4:0]    reg_s   [CW];
  logic [RB-1:0] idx_s   [CW];
  logic [CW-1:0] br_s, su_s, csr_s, ecall_s, ebrk_s, mret_s;
  logic [CW-1:0] done_s, slot_ok, event_s;
  logic [CW-1:0] elig, hit, retire;

  logic [63:0]    irq;
  logic           intr_pend, intr_take, live;
  logic           ab_any, ab_ecall, ab_ebrk, ab_mret;
  logic [63:0]    ab_pc;
  logic [2:0]     pop_d;
  logic [RPW-1:0] rel_d;
  logic           trap_d, xret_d;
  logic [63:0]    mcause_d;

  for (genvar gi = 0; gi < CW; gi++) begin : g_dec
    localparam int B = gi * IDW;
    assign pc_s[gi]    = rob.commit_fifo[B+IDW-1 -: 64];
    assign reg_s[gi]   = rob.commit_fifo[B+6+RB +: 5];
    assign idx_s[gi]   = rob.commit_fifo[B+6 +: RB];
    assign br_s[gi]    = rob.commit_fifo[B+5];
    assign su_s[gi]    = rob.commit_fifo[B+4];
    assign csr_s[gi]   = rob.commit_fifo[B+3];
    assign ecall_s[gi] = rob.commit_fifo[B+2];
    assign ebrk_s[gi]  = rob.commit_fifo[B+1];
    assign mret_s[gi]  = rob.commit_fifo[B+0];
    assign done_s[gi]  = wbLog_qout[{reg_s[gi], idx_s[gi]}];
    assign event_s[gi] = (br_s[gi] & rob.isMisPredict[gi]) | ecall_s[gi] | ebrk_s[gi] | mret_s[gi];
    // Serialising and privileged ops may only retire from the oldest slot.
    if (gi == 0) begin : g_head
      assign slot_ok[gi] = 1'b1;
    end else begin : g_tail
      assign slot_ok[gi] = ~(su_s[gi] | csr_s[gi] | ecall_s[gi] | ebrk_s[gi] | mret_s[gi]);
    end
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_archi
    assign archi_X_qout[gi*RB +: RB] = archi_q[gi];
  end

  assign irq       = mip_csr_out & mie_csr_out;
  assign intr_pend = (irq[11] | irq[7] | irq[3]) & mstatus_csr_out[3];
  assign intr_take = (state_q == S_RUN) & ~RST & rob.commit_vld[0] & intr_pend;
  assign live      = (state_q == S_RUN) & ~RST & ~intr_take;

  // Eligibility chains through the slots: a slot may go only if every older one retires.
  always_comb begin
    logic prior;
    prior  = 1'b1;
    elig   = '0;
    hit    = '0;
    retire = '0;
    for (int i = 0; i < CW; i++) begin
      elig[i]   = rob.commit_vld[i] & done_s[i] & slot_ok[i] & prior;
      hit[i]    = elig[i] & event_s[i] & live;
      retire[i] = elig[i] & ~event_s[i] & live;
      prior     = retire[i];
    end
  end

  always_comb begin
    ab_any   = 1'b0;
    ab_pc    = pc_s[0];
    ab_ecall = 1'b0;
    ab_ebrk  = 1'b0;
    ab_mret  = 1'b0;
    for (int i = CW - 1; i >= 0; i--) begin
      if (hit[i]) begin
        ab_any   = 1'b1;
        ab_pc    = pc_s[i];
        ab_ecall = ecall_s[i];
        ab_ebrk  = ebrk_s[i];
        ab_mret  = mret_s[i];
      end
    end
  end

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < CW; i++) begin
      pop_d = pop_d + 3'(retire[i]);
    end
  end

  // Walk retiring slots oldest-first so a later write to the same register frees the earlier one.
  always_comb begin
    map_d = archi_q;
    rel_d = '0;
    for (int j = 0; j < CW; j++) begin
      if (retire[j]) begin
        rel_d[{reg_s[j], map_d[reg_s[j]]}] = 1'b1;
        map_d[reg_s[j]] = idx_s[j];
      end
    end
  end

  assign trap_d = intr_take | (ab_any & (ab_ecall | ab_ebrk));
  assign xret_d = ab_any & ~ab_ecall & ~ab_ebrk & ab_mret;

  always_comb begin
    mcause_d = '0;
    if (intr_take) begin
      mcause_d[63] = 1'b1;
      if (irq[11])     mcause_d[3:0] = 4'd11;
      else if (irq[3]) mcause_d[3:0] = 4'd3;
      else             mcause_d[3:0] = 4'd7;
    end else if (ab_any & ab_ecall) begin
      mcause_d[3:0] = 4'd11;
    end else if (ab_any & ab_ebrk) begin
      mcause_d[3:0] = 4'd3;
    end
  end

  always_comb begin
    mstatus_except_in = '0;
    if (!RST) begin
      mstatus_except_in[3]     = xret_d & mstatus_csr_out[7];
      mstatus_except_in[7]     = trap_d ? mstatus_csr_out[3] : 1'b1;
      mstatus_except_in[12:11] = 2'b11;
    end
  end

  assign rob.reOrder_fifo_pop = pop_d;
  assign wbLog_commit_rst     = rel_d;
  assign rnBufU_commit_rst    = rel_d;
  assign commit_abort         = intr_take | ab_any;
  assign commit_pc            = RST ? 64'd0 : ab_pc;
  assign suILP_ready          = ~RST & su_s[0] & elig[0];
  assign isTrap               = trap_d;
  assign isXRet               = xret_d;
  assign privileged_pc        = trap_d ? mtvec_csr_out : (xret_d ? mepc_csr_out : 64'd0);
  assign mcause_except_in     = mcause_d;
  assign mepc_except_in       = trap_d ? ab_pc : 64'd0;
  assign mtval_except_in      = 64'd0;

  assign state_d = (state_q == S_RUN && commit_abort) ? S_FLUSH : S_RUN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_RUN;
      for (int r = 0; r < 32; r++) begin
        archi_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      archi_q <= map_d;
    end
  end

`ifdef COMMIT_INSTRET_EN
  logic [63:0] instret_q, instret_d;
  assign instret_d   = instret_q + 64'(pop_d);
  assign instret_cnt = instret_q;
  always_ff @(posedge CLK) begin
    if (RST) instret_q <= '0;
    else     instret_q <= instret_d;
  end
`endif

  wire unused_inputs = ^{irq[63:12], irq[10:8], irq[6:4], irq[2:0],
                         mstatus_csr_out[63:8], mstatus_csr_out[6:4], mstatus_csr_out[2:0],
                         su_s[CW-1:0], csr_s[CW-1:0]};

endmodule
